// File: rtl/segre_pkg.sv
// Shared types for the segre fetch front end: queue entry layout, fetch FSM states, default sizes.
package segre_pkg;
  localparam int ADDR_SIZE_DEF         = 32;
  localparam int WORD_SIZE_DEF         = 32;
  localparam int FETCH_QUEUE_DEPTH_DEF = 4;

  typedef struct packed {
    logic [ADDR_SIZE_DEF-1:0] pc;
    logic [WORD_SIZE_DEF-1:0] instr;
  } fetch_entry_t;

  typedef enum logic {FETCH, MISS_WAIT} fetch_state_e;
endpackage

// File: rtl/segre_fetch_queue.sv
// Circular FIFO of fetch entries with push, pop, flush, count, full and empty.
module segre_fetch_queue
  import segre_pkg::*;
#(
  parameter type T     = fetch_entry_t,
  parameter int  DEPTH = FETCH_QUEUE_DEPTH_DEF,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output T              data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);
  T              r_mem [DEPTH];
  logic [PW-1:0] r_rd, r_wr;
  logic [CW-1:0] r_cnt;
  logic          w_push, w_pop;

  assign full_o  = (r_cnt == CW'(DEPTH));
  assign empty_o = (r_cnt == '0);
  assign count_o = r_cnt;
  assign data_o  = r_mem[r_rd];
  assign w_push  = push_i && !full_o && !flush_i;
  assign w_pop   = pop_i && !empty_o && !flush_i;

  // DEPTH is a power of two, so pointers wrap naturally
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd  <= '0;
      r_wr  <= '0;
      r_cnt <= '0;
    end else if (flush_i) begin
      r_rd  <= r_wr;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + PW'(1);
      if (w_pop)  r_rd <= r_rd + PW'(1);
      r_cnt <= r_cnt + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (w_push && !rst_i) r_mem[r_wr] <= data_i;
  end
endmodule

// File: rtl/segre_if_fetch_queue.sv
// Instruction fetch stage: sequential PC generation, I-cache lookup, decoupling queue, WB redirects.
module segre_if_fetch_queue
  import segre_pkg::*;
#(
  parameter int                 ADDR_SIZE         = ADDR_SIZE_DEF,
  parameter int                 WORD_SIZE         = WORD_SIZE_DEF,
  parameter int                 FETCH_QUEUE_DEPTH = FETCH_QUEUE_DEPTH_DEF,
  parameter logic [ADDR_SIZE-1:0] RESET_PC        = '0,
  parameter int                 PERF_CNT_WIDTH    = 32,
  localparam int                CNT_W             = $clog2(FETCH_QUEUE_DEPTH + 1)
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  output logic                      icache_req_o,
  output logic [ADDR_SIZE-1:0]      icache_addr_o,
  input  logic                      icache_hit_i,
  input  logic [WORD_SIZE-1:0]      icache_instr_i,
  input  logic                      redirect_i,
  input  logic [ADDR_SIZE-1:0]      redirect_pc_i,
  input  logic                      id_ready_i,
  output logic                      valid_if_o,
  output logic [WORD_SIZE-1:0]      instr_o,
  output logic [ADDR_SIZE-1:0]      pc_o,
  output logic [CNT_W-1:0]          queue_count_o,
  output logic                      queue_full_o,
  output logic [PERF_CNT_WIDTH-1:0] miss_cycles_o
);
  typedef struct packed {
    logic [ADDR_SIZE-1:0] pc;
    logic [WORD_SIZE-1:0] instr;
  } entry_t;

  logic [ADDR_SIZE-1:0]      r_fetch_pc;
  logic [PERF_CNT_WIDTH-1:0] r_miss_cycles;
  fetch_state_e              r_state, w_state_nxt;
  logic                      w_req, w_push, w_pop, w_full, w_empty;
  logic [CNT_W-1:0]          w_count;
  entry_t                    w_wdata, w_head;

  // Full blocks the request outright: no combinational ready->req path
  assign w_req   = !rst_i && !redirect_i && !w_full;
  assign w_push  = w_req && icache_hit_i;
  assign w_pop   = valid_if_o && id_ready_i;
  assign w_wdata = '{pc: r_fetch_pc, instr: icache_instr_i};

  segre_fetch_queue #(.T(entry_t), .DEPTH(FETCH_QUEUE_DEPTH)) u_queue (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (w_push),
    .data_i  (w_wdata),
    .pop_i   (w_pop),
    .flush_i (redirect_i),
    .data_o  (w_head),
    .count_o (w_count),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  assign icache_req_o  = w_req;
  assign icache_addr_o = r_fetch_pc;
  assign valid_if_o    = !rst_i && !redirect_i && !w_empty;
  assign instr_o       = w_head.instr;
  assign pc_o          = w_head.pc;
  assign queue_count_o = rst_i ? '0 : w_count;
  assign queue_full_o  = !rst_i && w_full;
  assign miss_cycles_o = r_miss_cycles;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fetch_pc    <= RESET_PC;
      r_state       <= FETCH;
      r_miss_cycles <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (redirect_i)  r_fetch_pc <= {redirect_pc_i[ADDR_SIZE-1:2], 2'b00};
      else if (w_push) r_fetch_pc <= r_fetch_pc + ADDR_SIZE'(4);
      if (r_state == MISS_WAIT && !(&r_miss_cycles))
        r_miss_cycles <= r_miss_cycles + PERF_CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      FETCH:     if (w_req && !icache_hit_i) w_state_nxt = MISS_WAIT;
      MISS_WAIT: if (redirect_i || (w_req && icache_hit_i)) w_state_nxt = FETCH;
      default:   w_state_nxt = FETCH;
    endcase
  end
endmodule

// File: tb/tb_segre_if_fetch_queue.sv
// Self-checking bench: vector table, directed corner sequences and random traffic against a queue model.
module tb_segre_if_fetch_queue;
  localparam int DEPTH = 4;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        icache_req_o;
  logic [31:0] icache_addr_o;
  logic        icache_hit_i = 1'b0;
  logic [31:0] icache_instr_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        id_ready_i = 1'b0;
  logic        valid_if_o;
  logic [31:0] instr_o, pc_o;
  logic [2:0]  queue_count_o;
  logic        queue_full_o;
  logic [31:0] miss_cycles_o;

  always #5 clk_i = ~clk_i;

  segre_if_fetch_queue dut (
    .clk_i(clk_i), .rst_i(rst_i), .icache_req_o(icache_req_o), .icache_addr_o(icache_addr_o),
    .icache_hit_i(icache_hit_i), .icache_instr_i(icache_instr_i), .redirect_i(redirect_i),
    .redirect_pc_i(redirect_pc_i), .id_ready_i(id_ready_i), .valid_if_o(valid_if_o),
    .instr_o(instr_o), .pc_o(pc_o), .queue_count_o(queue_count_o), .queue_full_o(queue_full_o),
    .miss_cycles_o(miss_cycles_o)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {logic [31:0] pc; logic [31:0] instr;} ent_t;
  ent_t        mq[$];
  logic [31:0] m_pc = '0;
  logic [31:0] m_miss = '0;
  bit          m_inmiss = 0;
  bit          c_rst, c_hit, c_redir, c_ready;
  logic [31:0] c_rpc;

  typedef struct {
    bit rdy; bit e_req; logic [31:0] e_addr; bit e_valid; logic [31:0] e_pc; int e_cnt;
  } vec_t;
  vec_t vt[$];

  function automatic logic [31:0] ins_of(logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic drive(bit r, bit h, bit rd, logic [31:0] rp, bit rdy);
    bit ereq, evld;
    @(negedge clk_i);
    rst_i = r; icache_hit_i = h; icache_instr_i = ins_of(m_pc);
    redirect_i = rd; redirect_pc_i = rp; id_ready_i = rdy;
    c_rst = r; c_hit = h; c_redir = rd; c_rpc = rp; c_ready = rdy;
    #1;
    ereq = !r && !rd && (mq.size() < DEPTH);
    evld = !r && !rd && (mq.size() != 0);
    chk("req", 32'(icache_req_o), 32'(ereq));
    chk("addr", icache_addr_o, m_pc);
    chk("valid", 32'(valid_if_o), 32'(evld));
    chk("count", 32'(queue_count_o), r ? 32'd0 : 32'(mq.size()));
    chk("full", 32'(queue_full_o), 32'(!r && mq.size() == DEPTH));
    chk("miss_cycles", miss_cycles_o, m_miss);
    if (evld) begin
      chk("pc_o", pc_o, mq[0].pc);
      chk("instr_o", instr_o, mq[0].instr);
    end
  endtask

  task automatic tick();
    bit req, vld;
    @(posedge clk_i);
    req = !c_rst && !c_redir && (mq.size() < DEPTH);
    vld = !c_rst && !c_redir && (mq.size() != 0);
    if (c_rst) begin
      mq.delete(); m_pc = 32'h0; m_miss = '0; m_inmiss = 0;
    end else begin
      if (m_inmiss && m_miss != 32'hFFFF_FFFF) m_miss++;
      if (c_redir) begin
        mq.delete(); m_pc = c_rpc & ~32'h3; m_inmiss = 0;
      end else begin
        if (vld && c_ready) void'(mq.pop_front());
        if (req && c_hit) begin
          mq.push_back('{pc: m_pc, instr: ins_of(m_pc)});
          m_pc = m_pc + 32'd4; m_inmiss = 0;
        end else if (req) m_inmiss = 1;
      end
    end
  endtask

  task automatic step(bit r, bit h, bit rd, logic [31:0] rp, bit rdy);
    drive(r, h, rd, rp, rdy);
    tick();
  endtask

  initial begin
    // Streaming hits, then back-pressure until full, then drain with one bubble
    vt.push_back('{1, 1, 32'h00, 0, 32'h00, 0});
    vt.push_back('{1, 1, 32'h04, 1, 32'h00, 1});
    vt.push_back('{1, 1, 32'h08, 1, 32'h04, 1});
    vt.push_back('{1, 1, 32'h0C, 1, 32'h08, 1});
    vt.push_back('{0, 1, 32'h10, 1, 32'h0C, 1});
    vt.push_back('{0, 1, 32'h14, 1, 32'h0C, 2});
    vt.push_back('{0, 1, 32'h18, 1, 32'h0C, 3});
    vt.push_back('{0, 0, 32'h1C, 1, 32'h0C, 4});
    vt.push_back('{1, 0, 32'h1C, 1, 32'h0C, 4});
    vt.push_back('{1, 1, 32'h1C, 1, 32'h10, 3});
    vt.push_back('{1, 1, 32'h20, 1, 32'h14, 3});

    c_rst = 1; c_hit = 0; c_redir = 0; c_rpc = '0; c_ready = 0;
    @(posedge clk_i); tick();
    step(1, 0, 0, 0, 0);

    foreach (vt[i]) begin
      drive(0, 1, 0, 0, vt[i].rdy);
      chk("tbl_req", 32'(icache_req_o), 32'(vt[i].e_req));
      chk("tbl_addr", icache_addr_o, vt[i].e_addr);
      chk("tbl_valid", 32'(valid_if_o), 32'(vt[i].e_valid));
      chk("tbl_cnt", 32'(queue_count_o), 32'(vt[i].e_cnt));
      if (vt[i].e_valid) chk("tbl_pc", pc_o, vt[i].e_pc);
      tick();
    end

    // Five-cycle miss at pc 8
    step(1, 0, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    step(0, 1, 0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 1);
    drive(0, 1, 0, 0, 1);
    chk("miss_addr_hold", icache_addr_o, 32'h8);
    tick();
    drive(0, 1, 0, 0, 1);
    chk("miss_cycles_5", miss_cycles_o, 32'd5);
    chk("miss_pc8_out", pc_o, 32'h8);
    tick();
    step(0, 1, 0, 0, 1);

    // Redirect with three queued entries
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
    drive(0, 1, 1, 32'h102, 1);
    chk("redir_valid", 32'(valid_if_o), 32'd0);
    tick();
    drive(0, 1, 0, 0, 1);
    chk("redir_cnt", 32'(queue_count_o), 32'd0);
    chk("redir_addr", icache_addr_o, 32'h100);
    tick();
    drive(0, 1, 0, 0, 1);
    chk("redir_first_pc", pc_o, 32'h100);
    tick();

    // Redirect abandoning a pending miss
    step(0, 1, 1, 32'h20, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    step(0, 0, 1, 32'h40, 1);
    drive(0, 1, 0, 0, 1);
    chk("miss_redir_addr", icache_addr_o, 32'h40);
    tick();
    drive(0, 1, 0, 0, 1);
    chk("miss_redir_pc", pc_o, 32'h40);
    tick();
    step(0, 1, 0, 0, 1);

    // Address wrap, then reset with two entries queued
    step(0, 1, 1, 32'hFFFF_FFFF, 0);
    step(0, 1, 0, 0, 0);
    drive(0, 1, 0, 0, 0);
    chk("wrap_addr", icache_addr_o, 32'h0);
    tick();
    step(1, 1, 0, 0, 0);
    drive(0, 0, 0, 0, 0);
    chk("rst_cnt", 32'(queue_count_o), 32'd0);
    chk("rst_valid", 32'(valid_if_o), 32'd0);
    chk("rst_addr", icache_addr_o, 32'h0);
    tick();

    // Random traffic against the model
    for (int i = 0; i < 600; i++)
      step($urandom_range(0, 99) < 2, $urandom_range(0, 99) < 75, $urandom_range(0, 99) < 5,
           $urandom, $urandom_range(0, 99) < 60);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
